prio_arbiter: RTL
=================

Name: prio_arbiter

Overview:
- Parametrised, registered successor to the team's 4-input combinational priority encoder.
- Arbitrates N request lines and grants exactly one requester at a time.
- Arbitration mode is selectable per grant: fixed LSB-first priority or round-robin.
- The grant is held until the requester releases it, withdraws its request, or times out.
- Sits in front of shared resources (bus, memory port) in the lab datapath.

Parameters:
- N, 8, number of request inputs; legal range 2..32.
- IDXW, $clog2(N), localparam; width of the grant index. Not overridable.
- TIMEOUT, 0, maximum grant hold in cycles; 0 disables the timeout.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  block enable; low forces the idle state.
- rr_mode  in  1  0 = fixed priority (index 0 highest), 1 = round-robin.
- req  in  N  request vector, one bit per requester.
- release_i  in  1  current grantee finished; ends the grant.
- gnt_idx  out  IDXW  index of the granted requester.
- gnt_valid  out  1  gnt_idx is valid and the grant is active.
- timeout_o  out  1  one-cycle pulse when a grant is force-released.

Behaviour:
- All state is updated on the rising edge of clk. Async reset has priority over everything.
- Reset values:
  - gnt_idx = 0, gnt_valid = 0, timeout_o = 0.
  - State = IDLE, round-robin pointer rr_ptr = 0, hold counter = 0.
- Reset asserted mid-grant: the grant is dropped immediately. No timeout_o pulse.
- Outputs never drive z. When gnt_valid = 0, gnt_idx = 0.
- States: IDLE and GRANT.
- enable = 0, any state: next edge goes to IDLE with gnt_valid = 0, gnt_idx = 0, counter = 0. rr_ptr is retained.
- IDLE with enable = 1 and |req = 1:
  - The winner is computed combinationally from req.
  - Next edge: state = GRANT, gnt_valid = 1, gnt_idx = winner.
  - Latency from req to gnt_valid is 1 cycle.
- IDLE with req = 0: stay in IDLE, outputs held at 0.
- Fixed mode: the lowest set index wins.
- Round-robin mode:
  - Search starts at rr_ptr, ascending, wrapping from N-1 to 0. The first set bit wins.
  - On each grant, rr_ptr = (winner + 1) mod N, in both modes.
- rr_mode is sampled only at the arbitration edge. Changing it during GRANT has no effect on the current grant.
- req is not sampled for new arbitration while in GRANT.
- GRANT ends at the next edge (to IDLE, gnt_valid = 0) on any of:
  - release_i = 1.
  - req[gnt_idx] = 0 (requester withdrew).
  - Timeout expiry.
- After a grant ends, IDLE lasts at least one cycle. The minimum gap between grants is 1 cycle.
- Timeout (TIMEOUT > 0):
  - The counter increments each GRANT cycle that has no other end condition.
  - When it reaches TIMEOUT-1, the next edge forces IDLE, and timeout_o = 1 for exactly that cycle.
  - The maximum grant length is TIMEOUT cycles.
  - Counter width is $clog2(TIMEOUT+1). The counter clears on entering GRANT.
- Simultaneous events:
  - release_i or a withdrawn request in the same cycle as expiry counts as a normal release: no timeout_o pulse.
  - enable = 0 overrides every GRANT end condition and never pulses timeout_o.
- TIMEOUT = 0: the counter logic is not generated and timeout_o is tied to 0.

Optional Feature:
- Macro: PRIO_ARB_ONEHOT_EN.
- Defined: adds output port gnt_onehot [N-1:0], registered.
  - Equals 1 << gnt_idx when gnt_valid = 1, else all zeros.
  - Updates on the same edge as gnt_idx. Reset value 0.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package prio_arb_pkg holds:
  - State enum (IDLE = 1'b0, GRANT = 1'b1).
  - Mode constants MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
- One sub-module, prio_find_first, is natural here.
  - Purely combinational, parameter N.
  - Inputs: req vector and start index. Outputs: found flag and index.
  - Performs the wrap-around search used by both modes; fixed mode passes start = 0.
  - Successor of the old encoder's for-loop style.

Test Plan:
- Reset/enable: N = 8, rst_n low with req = 8'hFF -> gnt_valid = 0, gnt_idx = 0. Release rst_n with enable = 0 -> outputs stay 0. Raise enable -> gnt_valid = 1, gnt_idx = 0 one cycle later.
- Fixed priority: rr_mode = 0, req = 8'b1010_1000 -> gnt_idx = 3. Pulse release_i -> 1 idle cycle, then gnt_idx = 3 again.
- Round-robin rotation: rr_mode = 1, req = 8'b1000_1001 held, release_i pulsed after each grant -> grant sequence 0, 3, 7, 0, with 1-cycle gaps.
- Withdrawal: grant on idx 5, then drop req[5] -> gnt_valid = 0 next edge, timeout_o never pulses.
- Timeout: TIMEOUT = 4, req = 8'h04, no release -> gnt_valid high for exactly 4 cycles, timeout_o pulses once, then re-grant of idx 2 after 1 idle cycle. Release on the expiry cycle -> no timeout_o pulse.
- Async reset mid-grant: assert rst_n low between clock edges -> gnt_valid and gnt_onehot clear immediately; rr_ptr = 0 afterwards, so round-robin restarts at idx 0.

Source files
------------

// File: rtl/prio_arb_pkg.sv
// rtl/prio_arb_pkg.sv - shared state and mode encodings for prio_arbiter
package prio_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_find_first.sv
// rtl/prio_find_first.sv - combinational wrap-around search for the first set request bit
module prio_find_first
  import prio_arb_pkg::*;
#(
  parameter int N = 8,
  localparam int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] start,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  logic [IDXW:0] pos;

  // Walk offsets from the far end back to start so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = {1'b0, start} + (IDXW + 1)'(i);
      if (pos >= (IDXW + 1)'(N)) begin
        pos = pos - (IDXW + 1)'(N);
      end
      if (req[pos[IDXW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IDXW-1:0];
      end
    end
  end

endmodule

// File: rtl/prio_arbiter.sv
// rtl/prio_arbiter.sv - registered N-way fixed/round-robin arbiter with grant hold and timeout
// Optional gnt_onehot output is built when PRIO_ARB_ONEHOT_EN is defined.
module prio_arbiter
  import prio_arb_pkg::*;
#(
  parameter int N       = 8,
  parameter int TIMEOUT = 0,
  localparam int IDXW   = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            rr_mode,
  input  logic [N-1:0]    req,
  input  logic            release_i,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
`ifdef PRIO_ARB_ONEHOT_EN
  output logic [N-1:0]    gnt_onehot,
`endif
  output logic            timeout_o
);

  state_t          state;
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] search_start;
  logic            win_found;
  logic [IDXW-1:0] win_idx;
  logic [IDXW-1:0] next_ptr;
  logic            end_other;
  logic            expire;

  assign search_start = (rr_mode == MODE_RR) ? rr_ptr : '0;
  assign next_ptr     = (win_idx == IDXW'(N - 1)) ? '0 : win_idx + IDXW'(1);
  assign end_other    = release_i || !req[gnt_idx];

  prio_find_first #(.N(N)) u_find (
    .req   (req),
    .start (search_start),
    .found (win_found),
    .idx   (win_idx)
  );

  generate
    if (TIMEOUT > 0) begin : g_tmo
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt;

      assign expire = (state == GRANT) && (cnt == CW'(TIMEOUT - 1));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (!enable || state == IDLE || end_other || expire) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end else begin : g_no_tmo
      assign expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      timeout_o <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      timeout_o <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        gnt_valid <= 1'b0;
        gnt_idx   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (win_found) begin
              state     <= GRANT;
              gnt_valid <= 1'b1;
              gnt_idx   <= win_idx;
              rr_ptr    <= next_ptr;
            end
          end
          GRANT: begin
            // A normal release on the expiry cycle wins, so no timeout pulse then.
            if (end_other) begin
              state     <= IDLE;
              gnt_valid <= 1'b0;
              gnt_idx   <= '0;
            end else if (expire) begin
              state     <= IDLE;
              gnt_valid <= 1'b0;
              gnt_idx   <= '0;
              timeout_o <= 1'b1;
            end
          end
          default: begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
          end
        endcase
      end
    end
  end

`ifdef PRIO_ARB_ONEHOT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_onehot <= '0;
    end else if (!enable) begin
      gnt_onehot <= '0;
    end else if (state == IDLE && win_found) begin
      gnt_onehot <= N'(1) << win_idx;
    end else if (state == GRANT && (end_other || expire)) begin
      gnt_onehot <= '0;
    end
  end
`endif

endmodule
